// File: rtl/ex_m_skid_reg.sv
// EX/MEM pipeline register with a valid/ready elastic handshake and a one-entry skid buffer.
// All state advances on the falling clock edge; reset is asynchronous and active-low.
module ex_m_skid_reg #(
  parameter int PC_SIZE   = 18,
  parameter int DATA_SIZE = 32,
  parameter int CTRL_W    = 6,
  parameter int RA_W      = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  // EX side
  input  logic                 EX_valid,
  output logic                 EX_ready,
  input  logic [CTRL_W-1:0]    EX_ctrl,
  input  logic [DATA_SIZE-1:0] EX_ALU_result,
  input  logic [DATA_SIZE-1:0] EX_Rt_data,
  input  logic [PC_SIZE-1:0]   EX_PCplus8,
  input  logic [RA_W-1:0]      EX_WR_out,
  input  logic                 flush,
  // MEM side
  output logic                 M_valid,
  input  logic                 M_ready,
  output logic [CTRL_W-1:0]    M_ctrl,
  output logic [DATA_SIZE-1:0] M_ALU_result,
  output logic [DATA_SIZE-1:0] M_Rt_data,
  output logic [PC_SIZE-1:0]   M_PCplus8,
  output logic [RA_W-1:0]      M_WR_out,
  // stall statistics
  output logic [CNT_W-1:0]     stall_cnt,
  input  logic                 cnt_clr,
  // occupancy (number of held entries: 0, 1 or 2)
  output logic [1:0]           dbg_state
);

  // Handshake: a side transfers on an edge where its valid and ready are both
  // high at that edge. EX_ready is a register output (high iff the skid is
  // empty), so it never depends combinationally on M_ready. Once M_valid is
  // high, the entry and its payload stay stable until M_ready takes it.

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;

  logic in_xfer;
  logic out_xfer;

  logic main_from_ex;
  logic main_from_skid;
  logic main_clear;
  logic skid_load;

  logic                 ex_ready_q;
  logic [CTRL_W-1:0]    m_ctrl_q;
  logic [DATA_SIZE-1:0] m_alu_q;
  logic [DATA_SIZE-1:0] m_rt_q;
  logic [PC_SIZE-1:0]   m_pc_q;
  logic [RA_W-1:0]      m_wr_q;

  logic [CTRL_W-1:0]    s_ctrl_q;
  logic [DATA_SIZE-1:0] s_alu_q;
  logic [DATA_SIZE-1:0] s_rt_q;
  logic [PC_SIZE-1:0]   s_pc_q;
  logic [RA_W-1:0]      s_wr_q;

  logic [CNT_W-1:0]     cnt_q;
  logic                 stall_inc;

  assign M_valid   = (state != S_EMPTY);
  assign in_xfer   = EX_valid & ex_ready_q;
  assign out_xfer  = M_valid & M_ready;
  assign stall_inc = M_valid & ~M_ready & ~flush;

  // State register
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_EMPTY;
      ex_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      ex_ready_q <= (state_nxt != S_TWO);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (in_xfer) state_nxt = S_ONE;
        S_ONE: begin
          if (out_xfer && !in_xfer)      state_nxt = S_EMPTY;
          else if (!out_xfer && in_xfer) state_nxt = S_TWO;
        end
        S_TWO:   if (out_xfer) state_nxt = S_ONE;
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // Output / datapath-enable logic
  always_comb begin
    main_from_ex   = 1'b0;
    main_from_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    if (!flush) begin
      case (state)
        S_EMPTY: main_from_ex = in_xfer;
        S_ONE: begin
          main_from_ex = out_xfer & in_xfer;
          main_clear   = out_xfer & ~in_xfer;
          skid_load    = ~out_xfer & in_xfer;
        end
        S_TWO:   main_from_skid = out_xfer;
        default: ;
      endcase
    end
  end

  // Main entry control: zero whenever the entry is not valid
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      m_ctrl_q <= '0;
    end else if (flush || main_clear) begin
      m_ctrl_q <= '0;
    end else if (main_from_ex) begin
      m_ctrl_q <= EX_ctrl;
    end else if (main_from_skid) begin
      m_ctrl_q <= s_ctrl_q;
    end
  end

  // Main entry payload: holds its last value when the entry empties or is flushed
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      m_alu_q <= '0;
      m_rt_q  <= '0;
      m_pc_q  <= '0;
      m_wr_q  <= '0;
    end else if (main_from_ex) begin
      m_alu_q <= EX_ALU_result;
      m_rt_q  <= EX_Rt_data;
      m_pc_q  <= EX_PCplus8;
      m_wr_q  <= EX_WR_out;
    end else if (main_from_skid) begin
      m_alu_q <= s_alu_q;
      m_rt_q  <= s_rt_q;
      m_pc_q  <= s_pc_q;
      m_wr_q  <= s_wr_q;
    end
  end

  // Skid entry
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      s_ctrl_q <= '0;
      s_alu_q  <= '0;
      s_rt_q   <= '0;
      s_pc_q   <= '0;
      s_wr_q   <= '0;
    end else if (skid_load) begin
      s_ctrl_q <= EX_ctrl;
      s_alu_q  <= EX_ALU_result;
      s_rt_q   <= EX_Rt_data;
      s_pc_q   <= EX_PCplus8;
      s_wr_q   <= EX_WR_out;
    end
  end

  // Saturating stall counter; clear wins over increment
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (stall_inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign EX_ready     = ex_ready_q;
  assign M_ctrl       = m_ctrl_q;
  assign M_ALU_result = m_alu_q;
  assign M_Rt_data    = m_rt_q;
  assign M_PCplus8    = m_pc_q;
  assign M_WR_out     = m_wr_q;
  assign stall_cnt    = cnt_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_ex_m_skid_reg.sv
// Bench for ex_m_skid_reg: queue-based reference model, per-cycle compare process,
// directed scenarios with literal expectations, then randomized streaming.
module tb_ex_m_skid_reg;

  localparam int PC_SIZE   = 18;
  localparam int DATA_SIZE = 32;
  localparam int CTRL_W    = 6;
  localparam int RA_W      = 5;
  localparam int CNT_W     = 4;
  localparam int ENT_W     = CTRL_W + 2 * DATA_SIZE + PC_SIZE + RA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                 clk;
  logic                 rst;
  logic                 EX_valid;
  logic                 EX_ready;
  logic [CTRL_W-1:0]    EX_ctrl;
  logic [DATA_SIZE-1:0] EX_ALU_result;
  logic [DATA_SIZE-1:0] EX_Rt_data;
  logic [PC_SIZE-1:0]   EX_PCplus8;
  logic [RA_W-1:0]      EX_WR_out;
  logic                 flush;
  logic                 M_valid;
  logic                 M_ready;
  logic [CTRL_W-1:0]    M_ctrl;
  logic [DATA_SIZE-1:0] M_ALU_result;
  logic [DATA_SIZE-1:0] M_Rt_data;
  logic [PC_SIZE-1:0]   M_PCplus8;
  logic [RA_W-1:0]      M_WR_out;
  logic [CNT_W-1:0]     stall_cnt;
  logic                 cnt_clr;
  logic [1:0]           dbg_state;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  // model state: entries in arrival order, last payload presented, stall count
  logic [ENT_W-1:0] exp_q[$];
  logic [ENT_W-1:0] last_pl;
  logic [CNT_W-1:0] mdl_cnt;

  ex_m_skid_reg #(
    .PC_SIZE(PC_SIZE), .DATA_SIZE(DATA_SIZE), .CTRL_W(CTRL_W), .RA_W(RA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .EX_valid(EX_valid), .EX_ready(EX_ready), .EX_ctrl(EX_ctrl),
    .EX_ALU_result(EX_ALU_result), .EX_Rt_data(EX_Rt_data),
    .EX_PCplus8(EX_PCplus8), .EX_WR_out(EX_WR_out), .flush(flush),
    .M_valid(M_valid), .M_ready(M_ready), .M_ctrl(M_ctrl),
    .M_ALU_result(M_ALU_result), .M_Rt_data(M_Rt_data),
    .M_PCplus8(M_PCplus8), .M_WR_out(M_WR_out),
    .stall_cnt(stall_cnt), .cnt_clr(cnt_clr), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: advances on each falling edge, cleared by reset
  initial begin
    int n;
    exp_q.delete();
    last_pl = '0;
    mdl_cnt = '0;
    forever begin
      @(negedge clk or negedge rst);
      if (!rst) begin
        exp_q.delete();
        last_pl = '0;
        mdl_cnt = '0;
      end else begin
        n = exp_q.size();
        if (cnt_clr) mdl_cnt = '0;
        else if (!flush && n > 0 && !M_ready && mdl_cnt != CNT_MAX) mdl_cnt = mdl_cnt + 1'b1;
        if (flush) begin
          exp_q.delete();
        end else begin
          if (n > 0 && M_ready) void'(exp_q.pop_front());
          if (EX_valid && n < 2)
            exp_q.push_back({EX_ctrl, EX_ALU_result, EX_Rt_data, EX_PCplus8, EX_WR_out});
        end
        if (exp_q.size() > 0) last_pl = exp_q[0];
      end
    end
  end

  // compare process: outputs settle at the falling edge, checked at the rising edge
  initial begin
    logic [ENT_W-1:0] head;
    logic [CTRL_W-1:0] e_ctrl;
    int n;
    forever begin
      @(posedge clk);
      if (chk_en) begin
        n = exp_q.size();
        head = last_pl;
        e_ctrl = '0;
        if (n > 0) e_ctrl = head[ENT_W-1 -: CTRL_W];
        chk("M_valid", 64'(M_valid), 64'(n > 0));
        chk("EX_ready", 64'(EX_ready), 64'(n < 2));
        chk("occupancy", 64'(dbg_state), 64'(n));
        chk("M_ctrl", 64'(M_ctrl), 64'(e_ctrl));
        chk("M_ALU_result", 64'(M_ALU_result), 64'(head[ENT_W-CTRL_W-1 -: DATA_SIZE]));
        chk("M_Rt_data", 64'(M_Rt_data), 64'(head[PC_SIZE+RA_W+DATA_SIZE-1 -: DATA_SIZE]));
        chk("M_PCplus8", 64'(M_PCplus8), 64'(head[PC_SIZE+RA_W-1 -: PC_SIZE]));
        chk("M_WR_out", 64'(M_WR_out), 64'(head[RA_W-1:0]));
        chk("stall_cnt", 64'(stall_cnt), 64'(mdl_cnt));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_SIZE-1:0] alu,
                       input logic [RA_W-1:0] wr);
    EX_valid      = v;
    EX_ctrl       = c;
    EX_ALU_result = alu;
    EX_Rt_data    = ~alu;
    EX_PCplus8    = PC_SIZE'(alu + 32'd8);
    EX_WR_out     = wr;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0; cnt_clr = 1'b0; M_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) tick();
    rst = 1'b1;

    // reset state
    chk("rst M_valid", 64'(M_valid), 64'd0);
    chk("rst EX_ready", 64'(EX_ready), 64'd1);
    chk("rst stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst M_ALU_result", 64'(M_ALU_result), 64'd0);

    // streaming with MEM always ready
    M_ready = 1'b1;
    drive(1'b1, 6'h02, 32'h10, 5'd1); tick();
    chk("stream0 alu", 64'(M_ALU_result), 64'h10);
    chk("stream0 valid", 64'(M_valid), 64'd1);
    drive(1'b1, 6'h02, 32'h14, 5'd2); tick();
    chk("stream1 alu", 64'(M_ALU_result), 64'h14);
    chk("stream1 ready", 64'(EX_ready), 64'd1);
    drive(1'b1, 6'h02, 32'h18, 5'd3); tick();
    chk("stream2 alu", 64'(M_ALU_result), 64'h18);
    chk("stream2 stall", 64'(stall_cnt), 64'd0);
    drive(1'b0, '0, '0, '0); tick();

    // skid: A held, B parked, three stalled edges, then drain in order
    M_ready = 1'b0;
    drive(1'b1, 6'h03, 32'hA, 5'd5); tick();
    drive(1'b1, 6'h05, 32'hB, 5'd6); tick();
    chk("skid EX_ready", 64'(EX_ready), 64'd0);
    chk("skid head wr", 64'(M_WR_out), 64'd5);
    drive(1'b0, '0, '0, '0); tick(); tick();
    chk("skid stall_cnt", 64'(stall_cnt), 64'd3);
    M_ready = 1'b1; tick();
    chk("drain B wr", 64'(M_WR_out), 64'd6);
    chk("drain B ctrl", 64'(M_ctrl), 64'h05);
    chk("drain EX_ready", 64'(EX_ready), 64'd1);
    tick();
    chk("drained valid", 64'(M_valid), 64'd0);
    chk("drained ctrl", 64'(M_ctrl), 64'd0);
    chk("drained wr held", 64'(M_WR_out), 64'd6);

    // flush with both entries full and C presented
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("clr stall_cnt", 64'(stall_cnt), 64'd0);
    M_ready = 1'b0;
    drive(1'b1, 6'h11, 32'hD, 5'd7); tick();
    drive(1'b1, 6'h12, 32'hE, 5'd8); tick();
    chk("full EX_ready", 64'(EX_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 6'h13, 32'hC, 5'd9); tick();
    flush = 1'b0;
    chk("flush valid", 64'(M_valid), 64'd0);
    chk("flush ctrl", 64'(M_ctrl), 64'd0);
    chk("flush EX_ready", 64'(EX_ready), 64'd1);
    chk("flush payload held", 64'(M_ALU_result), 64'hD);
    chk("flush stall_cnt", 64'(stall_cnt), 64'd1);
    drive(1'b0, '0, '0, '0); M_ready = 1'b1; tick(); tick();
    chk("C never out", 64'(M_valid), 64'd0);

    // saturation
    M_ready = 1'b0;
    drive(1'b1, 6'h21, 32'h77, 5'd10); tick();
    drive(1'b0, '0, '0, '0);
    repeat ((1 << CNT_W) + 5) tick();
    chk("sat stall_cnt", 64'(stall_cnt), 64'd15);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("sat clr", 64'(stall_cnt), 64'd0);

    // asynchronous reset mid-stall with the skid full
    drive(1'b1, 6'h22, 32'h78, 5'd11); tick();
    drive(1'b0, '0, '0, '0);
    chk("pre-rst EX_ready", 64'(EX_ready), 64'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async valid", 64'(M_valid), 64'd0);
    chk("async EX_ready", 64'(EX_ready), 64'd1);
    chk("async ctrl", 64'(M_ctrl), 64'd0);
    chk("async alu", 64'(M_ALU_result), 64'd0);
    chk("async wr", 64'(M_WR_out), 64'd0);
    chk("async stall", 64'(stall_cnt), 64'd0);
    tick();
    rst = 1'b1;
    M_ready = 1'b1;
    drive(1'b1, 6'h01, 32'h55, 5'd12); tick();
    drive(1'b0, '0, '0, '0);
    chk("post-rst valid", 64'(M_valid), 64'd1);
    chk("post-rst alu", 64'(M_ALU_result), 64'h55);
    tick();
    chk("post-rst single", 64'(M_valid), 64'd0);

    // randomized streaming against the model
    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 3) != 0), CTRL_W'($urandom_range(0, 63)), $urandom,
            RA_W'($urandom_range(0, 31)));
      M_ready = ($urandom_range(0, 9) < 7);
      flush   = ($urandom_range(0, 39) == 0);
      cnt_clr = ($urandom_range(0, 49) == 0);
      tick();
    end
    drive(1'b0, '0, '0, '0);
    flush = 1'b0; cnt_clr = 1'b0; M_ready = 1'b1;
    tick(); tick(); tick();

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_m_skid_reg.md
Name: ex_m_skid_reg

Overview:
Parametrised EX/MEM pipeline register with a valid/ready elastic handshake and a one-entry skid buffer, so the MEM stage can stall without losing an in-flight EX result. It carries the EX-stage control bundle, ALU result, Rt store data, PC+8 and the destination register number. It adds flush (bubble insertion) and a saturating stall-cycle counter. It sits between the EX stage and data memory, replacing the fixed-width, always-advancing EX/MEM latch.

Parameters:
PC_SIZE, 18, width of PC+8 field
DATA_SIZE, 32, width of ALU result and Rt data
CTRL_W, 6, control bundle width; bit0 MemtoReg, bit1 RegWrite, bit2 MemWrite, bit3 lh, bit4 sh, bit5 ALU_PC
RA_W, 5, register-address width
CNT_W, 16, stall counter width

Ports:
clk  in  1  pipeline clock; all state updates on the falling edge
rst  in  1  asynchronous, active-low reset
EX_valid  in  1  EX presents a valid instruction
EX_ready  out  1  register can accept this cycle
EX_ctrl  in  CTRL_W  control bundle
EX_ALU_result  in  DATA_SIZE  ALU result / memory address
EX_Rt_data  in  DATA_SIZE  store data
EX_PCplus8  in  PC_SIZE  link address
EX_WR_out  in  RA_W  destination register
flush  in  1  synchronous kill of all held entries
M_valid  out  1  MEM-side entry valid
M_ready  in  1  MEM stage consumes the entry this cycle
M_ctrl  out  CTRL_W  control bundle; all-zero whenever M_valid=0
M_ALU_result, M_Rt_data, M_PCplus8, M_WR_out  out  DATA_SIZE/DATA_SIZE/PC_SIZE/RA_W  payload
stall_cnt  out  CNT_W  saturating stall-cycle count
cnt_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Storage: main entry (drives the M_* outputs directly) and skid entry. Each has a valid bit.
- Input transfer (IN) = EX_valid & EX_ready. Output transfer (OUT) = M_valid & M_ready.
- EX_ready = ~skid_valid. It comes from a register with no combinational path from M_ready.
- Per falling edge, when flush=0:
  - main empty, IN: load main from EX; M_valid=1. Latency is one edge.
  - main full, OUT, skid full: main<-skid, skid empty. IN is impossible in this case.
  - main full, OUT, skid empty, IN: main<-EX.
  - main full, OUT, no IN: M_valid=0, M_ctrl<=0; payload holds its last value.
  - main full, no OUT, IN: skid<-EX; EX_ready falls after the edge.
  - main full, no OUT, no IN: hold everything.
- Ordering: entries leave in arrival order. No duplication, no loss.
- flush=1 (highest priority): clear M_valid and skid_valid, set M_ctrl<=0, and drop any same-edge IN. Payload registers keep their values. stall_cnt is unaffected.
- stall_cnt:
  - +1 on each edge with M_valid & ~M_ready and flush=0.
  - Saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 forces 0 and overrides increment.
- Reset (rst=0, asynchronous, any time including mid-transfer): all valids, M_ctrl, payload and stall_cnt go to 0. EX_ready=1 while in reset and after release. The first edge after release behaves as the empty case.
- Control bits pass through unmodified. Width is set only by CTRL_W, and no bit is decoded inside the block.

Test Plan:
- Reset, then EX_valid=1 with M_ready=1 and EX_ALU_result=0x00000010,0x14,0x18 on consecutive edges -> M_ALU_result follows one edge later; M_valid stays 1; EX_ready stays 1; stall_cnt=0.
- Load A (WR_out=5), hold M_ready=0, present B (WR_out=6) -> B goes to the skid and EX_ready=0 after the edge. Three stalled edges give stall_cnt=3. Raise M_ready -> A out, then B out, then EX_ready=1; order A,B.
- Main and skid full, assert flush with EX_valid=1 and C presented -> next edge M_valid=0, M_ctrl=6'b000000, EX_ready=1, and C is never output.
- Drive M_valid=1, M_ready=0 for 2^CNT_W+5 edges (CNT_W=4) -> stall_cnt sticks at 15. Pulse cnt_clr -> 0.
- Assert rst low mid-stall with the skid full -> all outputs 0 immediately, without a clock edge. After release, one EX_valid transfer gives a single M_valid entry.
- Streaming random EX_valid/M_ready for 1000 edges -> scoreboard shows in-order, lossless delivery with ctrl=0 on every invalid cycle.
